nonce_scheduler: RTL and testbench
==================================

Name: nonce_scheduler

Overview:
- Sequences the parallel SHA-256 nonce cores of the bitcoin hash engine: hands out nonces 0..NUM_NONCES-1 to free cores and collects each core's final H0 word.
- Owns the shared memory write port and writes each result to output_addr + nonce.
- Sits between the top-level FSM (after phase-1 midstate is ready) and the array of phase-2/phase-3 hash cores.

Parameters:
NUM_NONCES, 16, total nonces to hash per job (1..65535)
NUM_CORES, 4, number of hash cores shared (1..NUM_NONCES)

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
start  input  1  begin job; sampled only in IDLE
output_addr  input  16  result base address, latched on accepted start
core_start  output  NUM_CORES  one-hot, 1-cycle launch pulse to a core
core_nonce  output  32  nonce for the launched core; valid only while core_start != 0
core_done  input  NUM_CORES  per-core 1-cycle completion pulse
core_h0  input  32*NUM_CORES  per-core final H0; core i uses bits [32i+31:32i]; valid in core_done[i] cycle
mem_we  output  1  memory write enable
mem_addr  output  16  write address
mem_write_data  output  32  write data
done  output  1  1-cycle pulse when job complete
err  output  1  sticky protocol-error flag, cleared by accepted start

Behaviour:
- Reset values: core_start=0, core_nonce=0, mem_we=0, mem_addr=0, mem_write_data=0, done=0, err=0. All internal state is cleared: state=IDLE, busy/pending bits, nonce counter, write count, RR pointer=0.
- Asynchronous reset mid-job aborts immediately; no further writes occur; cores are not notified.
- States:
  - IDLE: on start go to RUN; latch base=output_addr; next_nonce=0; wr_count=0; err=0.
  - RUN: dispatch and write-back run concurrently every cycle. When wr_count reaches NUM_NONCES, go to FINISH.
  - FINISH: done=1 for exactly one cycle, then IDLE.
- start outside IDLE is ignored.
- Per-core state: busy bit, pending bit, 32-bit tag (nonce), 32-bit result register.
- Dispatch, at most one per cycle:
  - Condition: RUN and next_nonce < NUM_NONCES and some core has busy=0.
  - Select the lowest-index non-busy core i; drive core_start[i]=1 and core_nonce=next_nonce (registered outputs, same edge).
  - Set tag[i]=next_nonce and busy[i]=1; increment next_nonce.
  - First dispatch occurs on the cycle after start is accepted.
- Completion:
  - core_done[i] with busy[i]=1 and pending[i]=0: capture core_h0 slice into result[i] and set pending[i].
  - core_done[i] with busy[i]=0 or pending[i]=1: ignored, err<=1.
  - Several core_done bits in one cycle are all captured.
- Write-back, at most one per cycle:
  - Among pending cores, grant round-robin starting at rr_ptr. For granted core g, next cycle drives mem_we=1, mem_addr=base+tag[g][15:0] (16-bit wrap), mem_write_data=result[g].
  - Clear pending[g] and busy[g]; rr_ptr=(g+1) mod NUM_CORES; increment wr_count.
  - mem_we=0 otherwise.
- Latencies:
  - Result write appears the cycle after the core_done capture cycle at the earliest, so core_done→mem_we is minimum 2 edges.
  - A core freed by a write can be re-dispatched no earlier than the cycle after that write.
- Simultaneous events: a core_done capture and a write-back grant of a different core in the same cycle are both honoured. A core is never dispatched while busy.
- done asserts the cycle after the final mem_we.

Test Plan:
- Basic job, NUM_NONCES=16, NUM_CORES=4, output_addr=16'h0100, each core answers core_done 10 cycles after launch with h0 = 32'hA0000000 + nonce:
  - Launches: nonces 0,1,2,3 to cores 0,1,2,3 on cycles 1-4.
  - Writes: 16 writes, addr 0x0100+n with data A0000000+n.
  - done: one pulse after the 16th write.
- Simultaneous done, all 4 cores pulse core_done together:
  - Writes come out on 4 consecutive cycles in RR order from rr_ptr (0,1,2,3 initially).
  - Each freed core is relaunched the cycle after its write.
- Protocol error, spurious core_done[2] while core 2 is idle:
  - err=1 and stays 1; no write occurs; the job still completes.
  - Next start clears err.
- Address wrap, output_addr=16'hFFFE, NUM_NONCES=4: writes go to FFFE, FFFF, 0000, 0001.
- Reset mid-job, reset_n low after 5 writes:
  - All outputs read 0 immediately; no done pulse.
  - A new start runs the full 16-write job correctly.
- start pulsed during RUN: ignored; exactly NUM_NONCES writes and a single done.

Source files
------------

// File: rtl/nonce_scheduler.sv
// nonce_scheduler: hands nonces to free hash cores, collects H0, writes results.
// Ports: clk/reset_n; start+output_addr begin a job; core_start/core_nonce
// launch a core; core_done/core_h0 return results; mem_* writes base+nonce;
// done pulses at job end; err is a sticky flag for stray core_done pulses.
module nonce_scheduler #(
  parameter int NUM_NONCES = 16,
  parameter int NUM_CORES  = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [15:0]            output_addr,
  output logic [NUM_CORES-1:0]   core_start,
  output logic [31:0]            core_nonce,
  input  logic [NUM_CORES-1:0]   core_done,
  input  logic [32*NUM_CORES-1:0] core_h0,
  output logic                   mem_we,
  output logic [15:0]            mem_addr,
  output logic [31:0]            mem_write_data,
  output logic                   done,
  output logic                   err
);

  localparam int CW = 17;
  localparam int RW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [CW-1:0] NN = CW'(NUM_NONCES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FINISH
  } state_e;

  state_e state_q, state_d;

  logic [15:0]          base_q, base_d;
  logic [CW-1:0]        next_nonce_q, next_nonce_d;
  logic [CW-1:0]        wr_count_q, wr_count_d;
  logic [NUM_CORES-1:0] busy_q, busy_d;
  logic [NUM_CORES-1:0] pending_q, pending_d;
  logic [15:0]          tag_q [NUM_CORES];
  logic [15:0]          tag_d [NUM_CORES];
  logic [31:0]          res_q [NUM_CORES];
  logic [31:0]          res_d [NUM_CORES];
  logic [RW-1:0]        rr_q, rr_d;
  logic [NUM_CORES-1:0] core_start_q, core_start_d;
  logic [31:0]          core_nonce_q, core_nonce_d;
  logic                 mem_we_q, mem_we_d;
  logic [15:0]          mem_addr_q, mem_addr_d;
  logic [31:0]          mem_data_q, mem_data_d;
  logic                 err_q, err_d;

  logic                 accept;
  logic                 disp_hit;
  logic [RW-1:0]        disp_idx;
  logic                 wb_hit;
  logic [RW-1:0]        wb_idx;

  assign accept = (state_q == S_IDLE) && start;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_RUN;
      S_RUN:    if (wr_count_q == NN) state_d = S_FINISH;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    done           = (state_q == S_FINISH);
    core_start     = core_start_q;
    core_nonce     = core_nonce_q;
    mem_we         = mem_we_q;
    mem_addr       = mem_addr_q;
    mem_write_data = mem_data_q;
    err            = err_q;
  end

  // Lowest-index free core
  always_comb begin
    disp_hit = 1'b0;
    disp_idx = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        disp_hit = 1'b1;
        disp_idx = RW'(i);
      end
    end
  end

  // Round-robin pick among pending cores, starting at rr_q.
  // Scanning downwards leaves the candidate nearest rr_q.
  always_comb begin
    wb_hit = 1'b0;
    wb_idx = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      if (pending_q[(int'(rr_q) + k) % NUM_CORES]) begin
        wb_hit = 1'b1;
        wb_idx = RW'((int'(rr_q) + k) % NUM_CORES);
      end
    end
  end

  // Datapath
  always_comb begin
    base_d       = base_q;
    next_nonce_d = next_nonce_q;
    wr_count_d   = wr_count_q;
    busy_d       = busy_q;
    pending_d    = pending_q;
    tag_d        = tag_q;
    res_d        = res_q;
    rr_d         = rr_q;
    core_start_d = '0;
    core_nonce_d = '0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    err_d        = err_q;

    // A pending core cannot complete again until written back,
    // so capture never collides with the write-back grant.
    for (int i = 0; i < NUM_CORES; i++) begin
      if (core_done[i]) begin
        if (busy_q[i] && !pending_q[i]) begin
          res_d[i]     = core_h0[32*i +: 32];
          pending_d[i] = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
    end

    if (state_q == S_RUN) begin
      if (disp_hit && (next_nonce_q < NN)) begin
        core_start_d[disp_idx] = 1'b1;
        core_nonce_d           = 32'(next_nonce_q);
        busy_d[disp_idx]       = 1'b1;
        tag_d[disp_idx]        = next_nonce_q[15:0];
        next_nonce_d           = next_nonce_q + 1'b1;
      end
      if (wb_hit) begin
        mem_we_d          = 1'b1;
        mem_addr_d        = base_q + tag_q[wb_idx];
        mem_data_d        = res_q[wb_idx];
        pending_d[wb_idx] = 1'b0;
        busy_d[wb_idx]    = 1'b0;
        rr_d = (wb_idx == RW'(NUM_CORES - 1)) ? '0 : wb_idx + RW'(1);
        wr_count_d        = wr_count_q + 1'b1;
      end
    end

    if (accept) begin
      base_d       = output_addr;
      next_nonce_d = '0;
      wr_count_d   = '0;
      busy_d       = '0;
      pending_d    = '0;
      err_d        = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_q       <= '0;
      next_nonce_q <= '0;
      wr_count_q   <= '0;
      busy_q       <= '0;
      pending_q    <= '0;
      rr_q         <= '0;
      core_start_q <= '0;
      core_nonce_q <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      err_q        <= 1'b0;
      for (int i = 0; i < NUM_CORES; i++) begin
        tag_q[i] <= '0;
        res_q[i] <= '0;
      end
    end else begin
      base_q       <= base_d;
      next_nonce_q <= next_nonce_d;
      wr_count_q   <= wr_count_d;
      busy_q       <= busy_d;
      pending_q    <= pending_d;
      rr_q         <= rr_d;
      core_start_q <= core_start_d;
      core_nonce_q <= core_nonce_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      err_q        <= err_d;
      for (int i = 0; i < NUM_CORES; i++) begin
        tag_q[i] <= tag_d[i];
        res_q[i] <= res_d[i];
      end
    end
  end

endmodule

// File: tb/tb_nonce_scheduler.sv
// tb_nonce_scheduler: directed bench for nonce_scheduler.
// Cores are modelled with a fixed launch-to-done latency.
module tb_nonce_scheduler;

  localparam int NC  = 4;
  localparam int NN  = 16;
  localparam int LAT = 10;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [15:0]       output_addr = '0;
  logic [NC-1:0]     core_start;
  logic [31:0]       core_nonce;
  logic [NC-1:0]     core_done = '0;
  logic [32*NC-1:0]  core_h0 = '0;
  logic              mem_we;
  logic [15:0]       mem_addr;
  logic [31:0]       mem_write_data;
  logic              done;
  logic              err;

  nonce_scheduler #(
    .NUM_NONCES(NN),
    .NUM_CORES (NC)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .output_addr   (output_addr),
    .core_start    (core_start),
    .core_nonce    (core_nonce),
    .core_done     (core_done),
    .core_h0       (core_h0),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_write_data(mem_write_data),
    .done          (done),
    .err           (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] wr_addr [$];
  logic [31:0] wr_data [$];
  int          wr_cyc  [$];
  int          ln_core [$];
  logic [31:0] ln_nonce[$];
  int          ln_cyc  [$];
  int          done_cnt = 0;
  int          done_cyc = 0;

  // Monitor
  always @(posedge clk) begin
    #1;
    if (mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_write_data);
      wr_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    for (int i = 0; i < NC; i++) begin
      if (core_start[i]) begin
        ln_core.push_back(i);
        ln_nonce.push_back(core_nonce);
        ln_cyc.push_back(cyc);
      end
    end
  end

  // Core model
  logic          auto_en = 1'b1;
  logic          force_all = 1'b0;
  logic          kill = 1'b0;
  logic [NC-1:0] spur_mask = '0;
  logic          live [NC] = '{default: 1'b0};
  int            cnt  [NC] = '{default: 0};
  logic [31:0]   tg   [NC] = '{default: '0};

  always @(posedge clk) begin
    #1;
    core_done = spur_mask;
    core_h0   = '0;
    for (int i = 0; i < NC; i++) begin
      if (kill) begin
        live[i] = 1'b0;
      end else if (live[i]) begin
        if (auto_en) cnt[i]--;
        if ((auto_en && cnt[i] == 0) || force_all) begin
          core_done[i]        = 1'b1;
          core_h0[32*i +: 32] = 32'hA000_0000 + tg[i];
          live[i]             = 1'b0;
        end
      end
      if (core_start[i] && !kill) begin
        live[i] = 1'b1;
        cnt[i]  = LAT;
        tg[i]   = core_nonce;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    ln_core.delete();
    ln_nonce.delete();
    ln_cyc.delete();
    done_cnt = 0;
  endtask

  task automatic start_job(input logic [15:0] base, output int k0);
    @(negedge clk);
    output_addr = base;
    start       = 1'b1;
    k0          = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done_cnt == 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
    repeat (6) @(negedge clk);
  endtask

  task automatic check_job(input string tag, input logic [15:0] base);
    int n;
    chk({tag, "_nwrites"}, 32'(wr_addr.size()), 32'(NN));
    n = (wr_addr.size() < NN) ? wr_addr.size() : NN;
    for (int j = 0; j < n; j++) begin
      chk($sformatf("%s_addr%0d", tag, j), 32'(wr_addr[j]),
          32'(16'(base + 16'(j))));
      chk($sformatf("%s_data%0d", tag, j), wr_data[j],
          32'hA000_0000 + 32'(j));
    end
    chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    if (wr_cyc.size() > 0)
      chk({tag, "_done_lat"}, 32'(done_cyc), 32'(wr_cyc[$] + 1));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_core_start"}, 32'(core_start), 32'd0);
    chk({tag, "_core_nonce"}, core_nonce, 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, mem_write_data, 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    int k0;
    int m;
    int n;

    // Reset state
    repeat (2) @(negedge clk);
    chk_zero("rst");
    reset_n = 1'b1;
    @(negedge clk);

    // Basic job
    clear_logs();
    start_job(16'h0100, k0);
    wait_done("basic");
    for (int i = 0; i < 4; i++) begin
      if (ln_core.size() > i) begin
        chk($sformatf("basic_ln%0d_core", i), 32'(ln_core[i]), 32'(i));
        chk($sformatf("basic_ln%0d_nonce", i), ln_nonce[i], 32'(i));
        chk($sformatf("basic_ln%0d_cyc", i), 32'(ln_cyc[i]),
            32'(k0 + 1 + i));
      end
    end
    if (wr_cyc.size() > 0)
      chk("basic_first_wr_cyc", 32'(wr_cyc[0]), 32'(k0 + 13));
    if (ln_core.size() > 4 && wr_cyc.size() > 0) begin
      chk("basic_reln_core", 32'(ln_core[4]), 32'd0);
      chk("basic_reln_nonce", ln_nonce[4], 32'd4);
      chk("basic_reln_cyc", 32'(ln_cyc[4]), 32'(wr_cyc[0] + 1));
    end
    chk("basic_err", 32'(err), 32'd0);
    check_job("basic", 16'h0100);

    // Simultaneous completion
    clear_logs();
    auto_en = 1'b0;
    start_job(16'h0200, k0);
    n = 0;
    while (ln_core.size() < 4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("sim_launch4", 32'(ln_core.size() >= 4), 32'd1);
    repeat (3) @(negedge clk);
    chk("sim_no_wr_yet", 32'(wr_addr.size()), 32'd0);
    force_all = 1'b1;
    m = cyc;
    @(negedge clk);
    force_all = 1'b0;
    auto_en   = 1'b1;
    repeat (8) @(negedge clk);
    for (int j = 0; j < 4; j++) begin
      if (wr_cyc.size() > j)
        chk($sformatf("sim_wr%0d_cyc", j), 32'(wr_cyc[j]),
            32'(m + 3 + j));
      if (ln_core.size() > 4 + j) begin
        chk($sformatf("sim_reln%0d_core", j), 32'(ln_core[4 + j]),
            32'(j));
        chk($sformatf("sim_reln%0d_nonce", j), ln_nonce[4 + j],
            32'(4 + j));
        chk($sformatf("sim_reln%0d_cyc", j), 32'(ln_cyc[4 + j]),
            32'(m + 4 + j));
      end
    end
    wait_done("sim");
    check_job("sim", 16'h0200);

    // Spurious core_done while core 2 is still idle
    clear_logs();
    start_job(16'h0300, k0);
    spur_mask = 4'b0100;
    @(negedge clk);
    spur_mask = '0;
    @(negedge clk);
    chk("perr_set", 32'(err), 32'd1);
    wait_done("perr");
    chk("perr_sticky", 32'(err), 32'd1);
    check_job("perr", 16'h0300);

    // Address wrap; new start clears err
    clear_logs();
    start_job(16'hFFFE, k0);
    chk("wrap_err_clr", 32'(err), 32'd0);
    wait_done("wrap");
    check_job("wrap", 16'hFFFE);

    // Reset mid-job
    clear_logs();
    start_job(16'h0500, k0);
    n = 0;
    while (wr_addr.size() < 5 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rmid_5wr", 32'(wr_addr.size()), 32'd5);
    reset_n = 1'b0;
    kill    = 1'b1;
    #1;
    chk_zero("rmid");
    repeat (5) @(negedge clk);
    chk("rmid_nwr", 32'(wr_addr.size()), 32'd5);
    chk("rmid_nodone", 32'(done_cnt), 32'd0);
    reset_n = 1'b1;
    kill    = 1'b0;
    @(negedge clk);
    clear_logs();
    start_job(16'h0100, k0);
    wait_done("rnew");
    check_job("rnew", 16'h0100);

    // start pulsed while running
    clear_logs();
    start_job(16'h0600, k0);
    repeat (3) @(negedge clk);
    output_addr = 16'h0700;
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    repeat (18) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("srun");
    check_job("srun", 16'h0600);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
